// File: rtl/pc_ifid_stage.sv
// Fetch stage: program counter, next-PC select (PC+4 / branch / jump) and IF/ID register.
// Optional macro BRANCH_STATS_EN adds redirect and stall counters; otherwise both ports read 0.
module pc_ifid_stage #(
    parameter int unsigned          ADDR_W    = 32,
    parameter int unsigned          INSTR_W   = 32,
    parameter logic [ADDR_W-1:0]    RESET_PC  = 32'h0000_0000,
    parameter logic [INSTR_W-1:0]   NOP_INSTR = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                stall,
    input  logic                branch_sel,
    input  logic [ADDR_W-1:0]   branch_target,
    input  logic                jump,
    input  logic [ADDR_W-1:0]   jump_target,
    input  logic [INSTR_W-1:0]  instr_in,
    output logic [ADDR_W-1:0]   pc_out,
    output logic [INSTR_W-1:0]  if_id_instr,
    output logic [ADDR_W-1:0]   if_id_pc4,
    output logic                if_id_valid,
    output logic                flush,
    output logic [31:0]         redirect_cnt,
    output logic [31:0]         stall_cnt
);

    typedef enum logic {BOOT, RUN} state_t;

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0]   instr_q, instr_d;
    logic [ADDR_W-1:0]    pc4_q, pc4_d;
    logic                 valid_q, valid_d;

    logic                 redirect;
    logic                 run_stall;
    logic [ADDR_W-1:0]    pc_plus4;
    logic [ADDR_W-1:0]    target_raw;
    logic [ADDR_W-1:0]    target;

    assign pc_plus4   = pc_q + ADDR_W'(4);
    assign redirect   = (jump | branch_sel) & ~stall & (state_q == RUN);
    assign run_stall  = stall & (state_q == RUN);
    assign target_raw = jump ? jump_target : branch_target;
    // Masking rather than slicing keeps every target bit in use.
    assign target     = target_raw & ~ADDR_W'(3);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        unique case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (stall) begin
                    pc_d = pc_q;
                end else if (redirect) begin
                    pc_d    = target;
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                end else begin
                    pc_d    = pc_plus4;
                    instr_d = instr_in;
                    pc4_d   = pc_plus4;
                    valid_d = 1'b1;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign pc_out      = pc_q;
    assign if_id_instr = instr_q;
    assign if_id_pc4   = pc4_q;
    assign if_id_valid = valid_q;
    assign flush       = redirect;

`ifdef BRANCH_STATS_EN
    logic [31:0] redirect_cnt_q;
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            redirect_cnt_q <= '0;
            stall_cnt_q    <= '0;
        end else begin
            if (redirect)  redirect_cnt_q <= redirect_cnt_q + 32'd1;
            if (run_stall) stall_cnt_q    <= stall_cnt_q + 32'd1;
        end
    end

    assign redirect_cnt = redirect_cnt_q;
    assign stall_cnt    = stall_cnt_q;
`else
    logic unused_run_stall;
    assign unused_run_stall = run_stall;
    assign redirect_cnt     = '0;
    assign stall_cnt        = '0;
`endif

endmodule

// File: tb/tb_pc_ifid_stage.sv
// Self-checking bench for pc_ifid_stage: vector table driven through a scoreboard queue,
// followed by an asynchronous-reset-during-redirect sequence.
module tb_pc_ifid_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall;
    logic        branch_sel;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] instr_in;
    logic [31:0] pc_out;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        flush;
    logic [31:0] redirect_cnt;
    logic [31:0] stall_cnt;

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    pc_ifid_stage dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .stall         (stall),
        .branch_sel    (branch_sel),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .instr_in      (instr_in),
        .pc_out        (pc_out),
        .if_id_instr   (if_id_instr),
        .if_id_pc4     (if_id_pc4),
        .if_id_valid   (if_id_valid),
        .flush         (flush),
        .redirect_cnt  (redirect_cnt),
        .stall_cnt     (stall_cnt)
    );

    typedef struct {
        logic        stall;
        logic        bsel;
        logic        jump;
        logic [31:0] bt;
        logic [31:0] jt;
        logic [31:0] instr;
        logic        eflush;
        logic [31:0] epc;
        logic [31:0] einstr;
        logic [31:0] epc4;
        logic        evalid;
        logic [31:0] erc;
        logic [31:0] esc;
    } vec_t;

    vec_t vt [15];
    vec_t sb [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] cnt_exp(input logic [31:0] v);
`ifdef BRANCH_STATS_EN
        return v;
`else
        return (v & 32'h0);
`endif
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        v;
        logic [31:0] pc_now;

        //          stall bsel jump bt            jt         instr         fl  epc           einstr        epc4   ev rc sc
        vt[0]  = '{1'b0,1'b0,1'b1,32'h0,        32'h80,    32'h2008_0005,1'b0,32'h0,       32'h0,        32'h0,  1'b0,0,0};
        vt[1]  = '{1'b0,1'b0,1'b0,32'h0,        32'h0,     32'h2008_0005,1'b0,32'h4,       32'h2008_0005,32'h4,  1'b1,0,0};
        vt[2]  = '{1'b0,1'b0,1'b0,32'h0,        32'h0,     32'h1111_1111,1'b0,32'h8,       32'h1111_1111,32'h8,  1'b1,0,0};
        vt[3]  = '{1'b0,1'b0,1'b0,32'h0,        32'h0,     32'h2222_2222,1'b0,32'hC,       32'h2222_2222,32'hC,  1'b1,0,0};
        vt[4]  = '{1'b0,1'b0,1'b0,32'h0,        32'h0,     32'h3333_3333,1'b0,32'h10,      32'h3333_3333,32'h10, 1'b1,0,0};
        vt[5]  = '{1'b0,1'b1,1'b0,32'h40,       32'h0,     32'h4444_4444,1'b1,32'h40,      32'h0,        32'h10, 1'b0,1,0};
        vt[6]  = '{1'b0,1'b0,1'b0,32'h0,        32'h0,     32'h5555_5555,1'b0,32'h44,      32'h5555_5555,32'h44, 1'b1,1,0};
        vt[7]  = '{1'b1,1'b1,1'b0,32'h200,      32'h0,     32'h6666_6666,1'b0,32'h44,      32'h5555_5555,32'h44, 1'b1,1,1};
        vt[8]  = '{1'b1,1'b1,1'b0,32'h200,      32'h0,     32'h6666_6666,1'b0,32'h44,      32'h5555_5555,32'h44, 1'b1,1,2};
        vt[9]  = '{1'b0,1'b0,1'b0,32'h0,        32'h0,     32'h6666_6666,1'b0,32'h48,      32'h6666_6666,32'h48, 1'b1,1,2};
        vt[10] = '{1'b0,1'b1,1'b1,32'h200,      32'h103,   32'h7777_7777,1'b1,32'h100,     32'h0,        32'h48, 1'b0,2,2};
        vt[11] = '{1'b0,1'b1,1'b0,32'hFFFF_FFFF,32'h0,     32'h8888_8888,1'b1,32'hFFFF_FFFC,32'h0,       32'h48, 1'b0,3,2};
        vt[12] = '{1'b0,1'b0,1'b0,32'h0,        32'h0,     32'h9999_9999,1'b0,32'h0,       32'h9999_9999,32'h0,  1'b1,3,2};
        vt[13] = '{1'b1,1'b0,1'b1,32'h0,        32'h300,   32'hAAAA_AAAA,1'b0,32'h0,       32'h9999_9999,32'h0,  1'b1,3,3};
        vt[14] = '{1'b0,1'b0,1'b0,32'h0,        32'h0,     32'hAAAA_AAAA,1'b0,32'h4,       32'hAAAA_AAAA,32'h4,  1'b1,3,3};

        reset_n = 1'b0; stall = 1'b0; branch_sel = 1'b0; jump = 1'b0;
        branch_target = '0; jump_target = '0; instr_in = 32'h2008_0005;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc",    pc_out,       32'h0);
        chk("rst_instr", if_id_instr,  32'h0);
        chk("rst_pc4",   if_id_pc4,    32'h0);
        chk("rst_valid", {31'b0, if_id_valid}, 32'h0);
        chk("rst_rcnt",  redirect_cnt, 32'h0);
        chk("rst_scnt",  stall_cnt,    32'h0);

        @(negedge clk);
        reset_n = 1'b1;
        pc_now  = 32'h0;
        for (int i = 0; i < 15; i++) begin
            if (i != 0) @(negedge clk);
            stall = vt[i].stall; branch_sel = vt[i].bsel; jump = vt[i].jump;
            branch_target = vt[i].bt; jump_target = vt[i].jt; instr_in = vt[i].instr;
            sb.push_back(vt[i]);
            #1;
            chk($sformatf("v%0d_flush", i), {31'b0, flush}, {31'b0, vt[i].eflush});
            chk($sformatf("v%0d_pcnow", i), pc_out, pc_now);
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                chk($sformatf("v%0d_sb", i), 32'h0, 32'h1);
            end else begin
                v = sb.pop_front();
                chk($sformatf("v%0d_pc", i),    pc_out,       v.epc);
                chk($sformatf("v%0d_instr", i), if_id_instr,  v.einstr);
                chk($sformatf("v%0d_pc4", i),   if_id_pc4,    v.epc4);
                chk($sformatf("v%0d_valid", i), {31'b0, if_id_valid}, {31'b0, v.evalid});
                chk($sformatf("v%0d_rcnt", i),  redirect_cnt, cnt_exp(v.erc));
                chk($sformatf("v%0d_scnt", i),  stall_cnt,    cnt_exp(v.esc));
                pc_now = v.epc;
            end
        end

        // Asynchronous reset lands mid-cycle while a branch redirect is pending.
        @(negedge clk);
        stall = 1'b0; jump = 1'b0; branch_sel = 1'b1; branch_target = 32'h500;
        instr_in = 32'hBBBB_BBBB;
        #1;
        chk("ar_flush_before", {31'b0, flush}, 32'h1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("ar_pc",    pc_out,      32'h0);
        chk("ar_instr", if_id_instr, 32'h0);
        chk("ar_pc4",   if_id_pc4,   32'h0);
        chk("ar_valid", {31'b0, if_id_valid}, 32'h0);
        chk("ar_flush", {31'b0, flush}, 32'h0);
        chk("ar_rcnt",  redirect_cnt, 32'h0);
        chk("ar_scnt",  stall_cnt,    32'h0);
        branch_sel = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ar_boot_pc",    pc_out, 32'h0);
        chk("ar_boot_valid", {31'b0, if_id_valid}, 32'h0);
        @(posedge clk);
        #1;
        chk("ar_run_pc",    pc_out,      32'h4);
        chk("ar_run_instr", if_id_instr, 32'hBBBB_BBBB);
        chk("ar_run_pc4",   if_id_pc4,   32'h4);
        chk("ar_run_valid", {31'b0, if_id_valid}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
